// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: four-digit multiplexed seven-segment driver for
// common-anode displays.
//
// The driver shows one digit slot at a time. Each slot is DIGIT_CYCLES long,
// and its first DEAD_CYCLES clocks are blanked so the previous digit cannot
// ghost onto the next. The display word and brightness are latched only on the
// last cycle of digit 3, so a frame never tears mid-scan.
//
// Optional PWM dimming is enabled by defining SSEG_SCAN_DRIVER_PWM_EN. Without
// it, i_bright is ignored and every non-dead cycle is lit.
//
// Parameter constraints:
//   DIGIT_CYCLES >= 2
//   DEAD_CYCLES  <  DIGIT_CYCLES
//   DIGIT_CYCLES <= 2**CNT_W

// Per-digit slice: decides whether this digit owns the pins and, if so,
// converts its active-high byte to active-low cathodes.
module sseg_scan_lane #(
  parameter logic [1:0] LANE = 2'd0
) (
  input  logic [1:0] i_dig,
  input  logic       i_lit,
  input  logic [7:0] i_byte,
  output logic       o_an_n,
  output logic [7:0] o_seg_n
);

  logic w_on;

  assign w_on    = i_lit && (i_dig == LANE);
  assign o_an_n  = ~w_on;
  // Unselected lanes drive all-ones so the top can AND-combine the lanes.
  assign o_seg_n = w_on ? ~i_byte : 8'hff;

endmodule

module sseg_scan_driver #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned DEAD_CYCLES  = 1000,
  parameter int unsigned CNT_W        = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_sseg,
  input  logic [3:0]  i_bright,
  output logic [3:0]  o_an,
  output logic [7:0]  o_seg,
  output logic        o_frame
);

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0]                  r_cnt;
  logic [1:0]                        r_dig;
  logic [31:0]                       r_frame;
  logic [3:0]                        r_an;
  logic [7:0]                        r_seg;
  logic                              r_frame_stb;

  logic                              w_wrap;
  logic                              w_latch;
  logic                              w_past_dead;
  logic                              w_pwm_on;
  logic                              w_lit;
  logic [NUM_DIGITS-1:0]             w_an_n;
  logic [NUM_DIGITS-1:0][7:0]        w_lane_seg;
  logic [7:0]                        w_seg_n;

  assign w_wrap  = (r_cnt == CNT_LAST);
  // The last cycle of digit 3 is the only frame boundary.
  assign w_latch = w_wrap && (r_dig == 2'd3);

  // With no dead time, every slot cycle is past the blanking window.
  // Splitting this case avoids a comparison that is always true.
  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign w_past_dead = 1'b1;
    end else begin : g_dead
      assign w_past_dead = (r_cnt >= CNT_W'(DEAD_CYCLES));
    end
  endgenerate

`ifdef SSEG_SCAN_DRIVER_PWM_EN
  logic [3:0] r_pwm;
  logic [3:0] r_bright;

  // Free-running PWM phase, plus the brightness that is latched with the frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pwm    <= 4'd0;
      r_bright <= 4'hf;
    end else begin
      r_pwm <= r_pwm + 4'd1;
      if (w_latch) r_bright <= i_bright;
    end
  end

  // Level 15 stays on every cycle; level 0 is on one cycle in 16.
  assign w_pwm_on = (r_pwm <= r_bright);
`else
  logic w_unused_bright;

  assign w_unused_bright = ^i_bright;
  assign w_pwm_on        = 1'b1;
`endif

  assign w_lit = w_past_dead && w_pwm_on;

  // Slot counter and digit index. The digit advances when the slot wraps.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_dig <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_dig <= r_dig + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Frame latch: the display word only changes at the frame boundary.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_frame <= 32'd0;
    else if (w_latch) r_frame <= i_sseg;
  end

  // One lane per digit. Each lane contributes its own anode bit and a
  // cathode pattern that is all-ones unless that lane is selected.
  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
      sseg_scan_lane #(
        .LANE (2'(g))
      ) u_lane (
        .i_dig   (r_dig),
        .i_lit   (w_lit),
        .i_byte  (r_frame[8*g +: 8]),
        .o_an_n  (w_an_n[g]),
        .o_seg_n (w_lane_seg[g])
      );
    end
  endgenerate

  // Merge the active-low cathode patterns. At most one lane is not all-ones.
  always_comb begin
    w_seg_n = 8'hff;
    for (int i = 0; i < NUM_DIGITS; i++) w_seg_n = w_seg_n & w_lane_seg[i];
  end

  // Registered pins, so the outputs follow the scan state by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_an        <= 4'hf;
      r_seg       <= 8'hff;
      r_frame_stb <= 1'b0;
    end else begin
      r_an        <= w_an_n;
      r_seg       <= w_seg_n;
      r_frame_stb <= w_latch;
    end
  end

  assign o_an    = r_an;
  assign o_seg   = r_seg;
  assign o_frame = r_frame_stb;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver.
//
// Two instances run in lockstep:
//   u_dut : DIGIT_CYCLES=8, DEAD_CYCLES=2
//   u_nd  : DIGIT_CYCLES=8, DEAD_CYCLES=0 (only its anode-active count per frame is scored)
//
// Stimulus pushes one expected-frame record per upcoming frame. The monitor
// opens a 32-cycle window after reset release or after each o_frame pulse,
// then scores every output cycle against the record it popped.
module tb_sseg_scan_driver;

`ifdef SSEG_SCAN_DRIVER_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif
  localparam int DEAD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sseg;
  logic [3:0]  bright;
  logic [3:0]  an, an0;
  logic [7:0]  seg, seg0;
  logic        frm, frm0;

  always #5 clk = ~clk;

  sseg_scan_driver #(
    .DIGIT_CYCLES (8),
    .DEAD_CYCLES  (DEAD),
    .CNT_W        (3)
  ) u_dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_sseg   (sseg),
    .i_bright (bright),
    .o_an     (an),
    .o_seg    (seg),
    .o_frame  (frm)
  );

  sseg_scan_driver #(
    .DIGIT_CYCLES (8),
    .DEAD_CYCLES  (0),
    .CNT_W        (3)
  ) u_nd (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_sseg   (sseg),
    .i_bright (bright),
    .o_an     (an0),
    .o_seg    (seg0),
    .o_frame  (frm0)
  );

  // seg_n holds the expected active-low cathodes: byte n belongs to digit n.
  // nd_on is the expected count of anode-active cycles on u_nd in that frame.
  typedef struct {
    logic [31:0] seg_n;
    logic [3:0]  bright;
    int          nd_on;
  } frame_t;

  frame_t q[$];
  int total       = 0;
  int bad         = 0;
  int frames_done = 0;
  logic rst_q  = 1'b0;
  logic rst_qq = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] s, input logic [3:0] b, input int n);
    frame_t f;
    f.seg_n  = s;
    f.bright = b;
    f.nd_on  = n;
    q.push_back(f);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns on the negedge of the o_frame cycle, i.e. state index 0 of a frame.
  task automatic wait_frame();
    bit got;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (frm === 1'b1) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL frame_wait: no o_frame within 100 cycles");
    end
  endtask

  always @(posedge clk) begin
    rst_qq <= rst_q;
    rst_q  <= rst;
  end

  // Monitor / scoreboard.
  initial begin : mon
    frame_t     cur;
    int         k, nd_cnt, i, d, c;
    bit         active, pend, lit;
    logic [3:0] ea;
    logic [7:0] es;
    k = 0; nd_cnt = 0; active = 1'b0; pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("rst_an", 32'(an), 32'hf);
        chk("rst_seg", 32'(seg), 32'hff);
        chk("rst_frame", 32'(frm), 32'h0);
        chk("rst_an_nd", 32'(an0), 32'hf);
        active = 1'b0;
        pend   = 1'b0;
      end else begin
        if ((rst_qq || pend) && q.size() > 0) begin
          cur    = q.pop_front();
          active = 1'b1;
          k      = 0;
          nd_cnt = 0;
        end
        pend = 1'b0;
        if (active) begin
          k++;
          i   = k - 1;
          d   = i / 8;
          c   = i % 8;
          lit = (c >= DEAD) && (!PWM || ((i % 16) <= int'(cur.bright)));
          ea  = 4'hf;
          es  = 8'hff;
          if (lit) begin
            ea[d] = 1'b0;
            es    = cur.seg_n[8*d +: 8];
          end
          chk($sformatf("an k=%0d", k), 32'(an), 32'(ea));
          chk($sformatf("seg k=%0d", k), 32'(seg), 32'(es));
          chk($sformatf("frame k=%0d", k), 32'(frm), (k == 32) ? 32'd1 : 32'd0);
          if (an0 !== 4'hf) nd_cnt++;
          if (k == 32) begin
            chk("nd_on_count", 32'(nd_cnt), 32'(cur.nd_on));
            active = 1'b0;
            frames_done++;
          end
        end
        if (frm === 1'b1) pend = 1'b1;
      end
    end
  end

  // Stimulus.
  initial begin : stim
    bit done;
    sseg   = 32'hFC60_DAF2;
    bright = 4'hf;
    rst    = 1'b1;

    // First frame after reset scans frame=0; then "0123" is latched.
    push(32'hFFFF_FFFF, 4'hf, 32);
    push(32'h039F_250D, 4'hf, 32);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Frame 2: change the word while dig=1; the change must not tear.
    wait_frame();
    step(10);
    sseg = 32'hFFFF_FFFF;
    push(32'h0000_0000, 4'hf, 32);

    // Frame 3: mid-frame brightness change becomes visible only in frame 4.
    wait_frame();
    step(5);
    bright = 4'h3;
    sseg   = 32'hFC60_DAF2;
    push(32'h039F_250D, 4'h3, PWM ? 8 : 32);

    // Frame 4: restore full brightness for frame 5.
    wait_frame();
    step(5);
    bright = 4'hf;
    push(32'h039F_250D, 4'hf, 32);

    // Frame 5: reset while dig=2.
    // The scan restarts with frame=0 and brightness back at full.
    wait_frame();
    step(18);
    bright = 4'h3;
    push(32'hFFFF_FFFF, 4'hf, 32);
    push(32'h039F_250D, 4'h3, PWM ? 8 : 32);
    rst = 1'b1;
    step(1);
    rst = 1'b0;

    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (frames_done >= 6) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL frames_done: got %0d want 6", frames_done);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
